// File: rtl/button_press_pulser_pkg.sv
// ---------------------------------------------------------------------------
// button_press_pulser_pkg
// Shared definitions for the button press pulser and its timer:
//   - state_t        : FSM state codes (ST_IDLE / ST_HOLD / ST_REPEAT)
//   - is_one_hot4    : true when a 4-bit button vector has exactly one bit set
//   - ms_to_cycles   : converts a time in ms to clock cycles at a given FCLK
// ---------------------------------------------------------------------------
package button_press_pulser_pkg;

    // Code 2'b11 is intentionally unused; the FSM recovers it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HOLD   = 2'b01,
        ST_REPEAT = 2'b10
    } state_t;

    // v & (v-1) clears the lowest set bit, so the result is zero only when
    // at most one bit was set; the non-zero test excludes the empty vector.
    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // 64-bit intermediate: FCLK * ms easily exceeds 32 bits at real clock rates.
    function automatic int ms_to_cycles(input longint fclk_hz, input longint ms);
        return int'((fclk_hz * ms) / 64'd1000);
    endfunction

endpackage

// File: rtl/pulse_interval_timer.sv
// ---------------------------------------------------------------------------
// pulse_interval_timer
// Up-counter used for the hold and auto-repeat intervals. Counts from zero
// after a clear and saturates at the terminal value; o_done is high while
// the count equals the terminal value.
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset (count -> 0)
//   i_clear     synchronous clear (count -> 0), higher priority than counting
//   i_terminal  terminal count to compare against / saturate at
//   o_done      high when count == i_terminal
// ---------------------------------------------------------------------------
module pulse_interval_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Count up from zero after every clear, holding at the terminal value so
    // the counter never wraps while the FSM sits in a state without a timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (r_count != i_terminal) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_done = (r_count == i_terminal);

endmodule

// File: rtl/button_press_pulser.sv
// ---------------------------------------------------------------------------
// button_press_pulser
// Turns a debounced, one-hot button level vector into single-cycle press,
// auto-repeat and release pulses plus a held-level vector. All outputs are
// registered.
// Parameters:
//   FCLK       clock frequency in Hz
//   HOLD_MS    hold time before the first auto-repeat pulse, in ms
//   REPEAT_MS  interval between subsequent auto-repeat pulses, in ms
//   REPEAT_EN  1 enables auto-repeat, 0 never issues repeat pulses
// Ports:
//   i_clk_mhz       system clock
//   i_rst_mhz       synchronous active-high reset
//   i_btns_deb      debounced button levels (one-hot or zero expected)
//   o_btns_press    one-cycle pulse of the captured button on press
//   o_btns_repeat   one-cycle pulse of the captured button on each repeat
//   o_btns_release  one-cycle pulse of the captured button on release
//   o_btns_held     captured button level while it is held
// ---------------------------------------------------------------------------
module button_press_pulser
    import button_press_pulser_pkg::*;
#(
    parameter int FCLK      = 20000000,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int REPEAT_EN = 1
) (
    input  logic       i_clk_mhz,
    input  logic       i_rst_mhz,
    input  logic [3:0] i_btns_deb,
    output logic [3:0] o_btns_press,
    output logic [3:0] o_btns_repeat,
    output logic [3:0] o_btns_release,
    output logic [3:0] o_btns_held
);

    localparam int C_HOLD = ms_to_cycles(FCLK, HOLD_MS);
    localparam int C_REP  = ms_to_cycles(FCLK, REPEAT_MS);
    localparam int C_MAX  = (C_HOLD > C_REP) ? C_HOLD : C_REP;
    localparam int TW     = $clog2(C_MAX);

    // The timer starts at 0 on entering a state, so a count of N-1 means the
    // event registers exactly N edges after the entry edge.
    localparam logic [TW-1:0] C_HOLD_T = TW'(C_HOLD - 1);
    localparam logic [TW-1:0] C_REP_T  = TW'(C_REP - 1);

    state_t      r_state;
    logic [3:0]  r_btn_store;
    logic [3:0]  r_press;
    logic [3:0]  r_repeat;
    logic [3:0]  r_release;
    logic [3:0]  r_held;

    state_t      w_state_next;
    logic [3:0]  w_store_next;
    logic [3:0]  w_press_next;
    logic [3:0]  w_repeat_next;
    logic [3:0]  w_release_next;
    logic [3:0]  w_held_next;
    logic        w_rep_fire;
    logic        w_timer_clear;
    logic        w_timer_done;
    logic [TW-1:0] w_terminal;

    // The timer restarts on every state change and after each repeat pulse
    // while staying in ST_REPEAT.
    assign w_timer_clear = (w_state_next != r_state) || w_rep_fire;

    pulse_interval_timer #(
        .WIDTH (TW)
    ) u_timer (
        .i_clk      (i_clk_mhz),
        .i_rst      (i_rst_mhz),
        .i_clear    (w_timer_clear),
        .i_terminal (w_terminal),
        .o_done     (w_timer_done)
    );

    // State, captured button and the output stage. Reset drops every output
    // immediately, so a reset while a button is held never emits a release.
    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            r_state     <= ST_IDLE;
            r_btn_store <= 4'b0000;
            r_press     <= 4'b0000;
            r_repeat    <= 4'b0000;
            r_release   <= 4'b0000;
            r_held      <= 4'b0000;
        end else begin
            r_state     <= w_state_next;
            r_btn_store <= w_store_next;
            r_press     <= w_press_next;
            r_repeat    <= w_repeat_next;
            r_release   <= w_release_next;
            r_held      <= w_held_next;
        end
    end

    // Next-state and next-output logic. The output values are those that
    // belong to the state being entered, so held rises together with press
    // and falls together with release. A change of input is checked before
    // timer expiry, so release always wins over a coincident repeat.
    always_comb begin
        w_state_next   = r_state;
        w_store_next   = r_btn_store;
        w_press_next   = 4'b0000;
        w_repeat_next  = 4'b0000;
        w_release_next = 4'b0000;
        w_held_next    = 4'b0000;
        w_rep_fire     = 1'b0;
        w_terminal     = C_HOLD_T;

        case (r_state)
            ST_IDLE: begin
                if (is_one_hot4(i_btns_deb)) begin
                    w_store_next = i_btns_deb;
                    w_press_next = i_btns_deb;
                    w_held_next  = i_btns_deb;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_held_next = r_btn_store;
                if (i_btns_deb != r_btn_store) begin
                    w_release_next = r_btn_store;
                    w_held_next    = 4'b0000;
                    w_state_next   = ST_IDLE;
                end else if ((REPEAT_EN != 0) && w_timer_done) begin
                    w_repeat_next = r_btn_store;
                    w_state_next  = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                w_terminal  = C_REP_T;
                w_held_next = r_btn_store;
                if (i_btns_deb != r_btn_store) begin
                    w_release_next = r_btn_store;
                    w_held_next    = 4'b0000;
                    w_state_next   = ST_IDLE;
                end else if (w_timer_done) begin
                    w_repeat_next = r_btn_store;
                    w_rep_fire    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_store_next = 4'b0000;
            end
        endcase
    end

    assign o_btns_press   = r_press;
    assign o_btns_repeat  = r_repeat;
    assign o_btns_release = r_release;
    assign o_btns_held    = r_held;

endmodule

// File: tb/tb_button_press_pulser.sv
// ---------------------------------------------------------------------------
// tb_button_press_pulser
// Self-checking bench for button_press_pulser. Two instances share the
// stimulus: dut0 with auto-repeat enabled, dut1 with auto-repeat disabled.
// Parameters give c_hold = 100 cycles and c_rep = 40 cycles.
// ---------------------------------------------------------------------------
module tb_button_press_pulser;

    localparam int C_HOLD = 100;
    localparam int C_REP  = 40;

    logic       clk;
    logic       rst;
    logic [3:0] btns;

    logic [3:0] press0, rep0, rel0, held0;
    logic [3:0] press1, rep1, rel1, held1;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [3:0] btns;
        logic       rst;
        logic [3:0] ePress;
        logic [3:0] eRepeat;
        logic [3:0] eRelease;
        logic [3:0] eHeld;
    } vec_t;

    vec_t vecs[18];

    button_press_pulser #(
        .FCLK      (20000),
        .HOLD_MS   (5),
        .REPEAT_MS (2),
        .REPEAT_EN (1)
    ) dut0 (
        .i_clk_mhz      (clk),
        .i_rst_mhz      (rst),
        .i_btns_deb     (btns),
        .o_btns_press   (press0),
        .o_btns_repeat  (rep0),
        .o_btns_release (rel0),
        .o_btns_held    (held0)
    );

    button_press_pulser #(
        .FCLK      (20000),
        .HOLD_MS   (5),
        .REPEAT_MS (2),
        .REPEAT_EN (0)
    ) dut1 (
        .i_clk_mhz      (clk),
        .i_rst_mhz      (rst),
        .i_btns_deb     (btns),
        .o_btns_press   (press1),
        .o_btns_repeat  (rep1),
        .o_btns_release (rel1),
        .o_btns_held    (held1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, then advance past the next rising edge so the registered
    // outputs of that edge can be sampled.
    task automatic applyStimulus(input logic [3:0] b, input logic r);
        btns = b;
        rst  = r;
        @(posedge clk);
        #1;
    endtask

    // Compare one instance's four outputs against the expected values.
    task automatic checkOutput(input string tag, input int sel,
                               input logic [3:0] ep, input logic [3:0] er,
                               input logic [3:0] erl, input logic [3:0] eh);
        logic [15:0] got;
        logic [15:0] want;
        got  = (sel == 0) ? {press0, rep0, rel0, held0} : {press1, rep1, rel1, held1};
        want = {ep, er, erl, eh};
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s: got press=%b rep=%b rel=%b held=%b, want press=%b rep=%b rel=%b held=%b",
                     tag, got[15:12], got[11:8], got[7:4], got[3:0],
                     want[15:12], want[11:8], want[7:4], want[3:0]);
        end
    endtask

    // Expected repeat edges relative to press edge k: k+c_hold, then every c_rep.
    function automatic bit isRepeatEdge(input int i);
        return (i >= C_HOLD) && (((i - C_HOLD) % C_REP) == 0);
    endfunction

    initial begin
        btns = 4'b0000;
        rst  = 1'b1;

        // {btns, rst, press, repeat, release, held} after the following edge
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
        vecs[4]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0110, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b0110, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        vecs[10] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        vecs[11] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
        vecs[12] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        vecs[14] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        vecs[16] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        for (int v = 0; v < 18; v++) begin
            applyStimulus(vecs[v].btns, vecs[v].rst);
            checkOutput($sformatf("vec%0d", v), 0, vecs[v].ePress, vecs[v].eRepeat,
                        vecs[v].eRelease, vecs[v].eHeld);
        end

        // Idle for 200 cycles: nothing may ever pulse.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput($sformatf("idle cyc%0d", i), 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        // Short press of 0100 for 20 cycles: one press, held throughout, one release.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0100, 1'b0);
            checkOutput($sformatf("short k+%0d", i), 0,
                        (i == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("short release", 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("short after", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Long hold of 0001 for 200 cycles: repeats at k+100, k+140, k+180.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOutput($sformatf("long k+%0d", i), 0,
                        (i == 0) ? 4'b0001 : 4'b0000,
                        isRepeatEdge(i) ? 4'b0001 : 4'b0000,
                        4'b0000, 4'b0001);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("long release", 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("long after", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Input drops right before edge k+100: release wins, no repeat.
        for (int i = 0; i < C_HOLD; i++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOutput($sformatf("race k+%0d", i), 0,
                        (i == 0) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("race release", 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("race after", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset at k+50 while holding 0010: outputs clear, no release, fresh press after.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(4'b0010, 1'b0);
            checkOutput($sformatf("rstmid k+%0d", i), 0,
                        (i == 0) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput("rstmid reset edge", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("rstmid fresh press", 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("rstmid held", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("rstmid release", 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000);

        // Auto-repeat disabled instance: hold 1000 for 300 cycles, press only.
        applyStimulus(4'b0000, 1'b1);
        checkOutput("norep reset", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'b1000, 1'b0);
            checkOutput($sformatf("norep k+%0d", i), 1,
                        (i == 0) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("norep release", 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
